// File: rtl/reg_bank_sequencer.sv
// Control-side sequencer for the CPU register bank: fetches 24-bit microinstructions
// over REQ/ACK and steps the bank's A/B/C selects, ALU op and MR strobe (Moore, all outputs registered).
module reg_bank_sequencer #(
    parameter int unsigned NREGS    = 35,
    parameter logic [5:0]  NULL_SEL = 6'd63,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic [23:0]      INSTR,
    input  logic             INSTR_ACK,
    output logic             INSTR_REQ,
    output logic [4:0]       A_CTRL,
    output logic [5:0]       B_CTRL,
    output logic [5:0]       C_CTRL,
    output logic             MR,
    output logic [2:0]       ALU_OP,
    output logic             BUSY,
    output logic             HALTED,
    output logic             ERR,
    output logic [CNT_W-1:0] INSTR_CNT
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_READ, S_WB, S_HALT} state_t;

    state_t             state, state_n;
    logic [23:0]        ir, ir_n;
    logic               req, req_n, mr, mr_n, busy, busy_n;
    logic               halted, halted_n, err, err_n, retire;
    logic [4:0]         a_sel, a_sel_n;
    logic [5:0]         b_sel, b_sel_n, c_sel, c_sel_n;
    logic [2:0]         alu, alu_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    function automatic logic [2:0] alu_dec(input logic [3:0] opc);
        alu_dec = (opc >= 4'd1 && opc <= 4'd6) ? 3'(opc - 4'd1) : 3'd0;
    endfunction

    // 28/29 collide with the bank's IN_0/IN_1 sampling; NULL_SEL is a legal discard
    function automatic logic c_bad(input logic [5:0] c);
        c_bad = (c != NULL_SEL) && ((32'(c) >= NREGS) || c == 6'd28 || c == 6'd29);
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            ir     <= '0;
            req    <= 1'b0;
            a_sel  <= '0;
            b_sel  <= NULL_SEL;
            c_sel  <= NULL_SEL;
            mr     <= 1'b0;
            alu    <= '0;
            busy   <= 1'b0;
            halted <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            ir     <= ir_n;
            req    <= req_n;
            a_sel  <= a_sel_n;
            b_sel  <= b_sel_n;
            c_sel  <= c_sel_n;
            mr     <= mr_n;
            alu    <= alu_n;
            busy   <= busy_n;
            halted <= halted_n;
            err    <= err_n;
            cnt    <= cnt_n;
        end
    end

    // Computes the values the output flops take in the *next* state
    always_comb begin
        state_n  = state;
        ir_n     = ir;
        req_n    = 1'b0;
        a_sel_n  = '0;
        b_sel_n  = NULL_SEL;
        c_sel_n  = NULL_SEL;
        mr_n     = 1'b0;
        alu_n    = '0;
        halted_n = halted;
        err_n    = err;
        cnt_n    = cnt;
        retire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (RUN) begin
                    state_n = S_FETCH;
                    req_n   = 1'b1;
                end
            end
            S_FETCH: begin
                if (INSTR_ACK) begin
                    ir_n    = INSTR;
                    state_n = S_READ;
                    a_sel_n = INSTR[13:9];
                    b_sel_n = INSTR[8:3];
                    alu_n   = alu_dec(INSTR[23:20]);
                    mr_n    = (INSTR[23:20] == 4'd7);
                end else begin
                    req_n = 1'b1;
                end
            end
            S_READ: begin
                if (ir[23:20] >= 4'd1 && ir[23:20] <= 4'd6) begin
                    state_n = S_WB;
                    a_sel_n = ir[13:9];
                    b_sel_n = ir[8:3];
                    alu_n   = alu_dec(ir[23:20]);
                    if (c_bad(ir[19:14])) begin
                        err_n = 1'b1;
                    end else begin
                        c_sel_n = ir[19:14];
                    end
                end else if (ir[23:20] == 4'd8) begin
                    state_n  = S_HALT;
                    halted_n = 1'b1;
                end else begin
                    retire = 1'b1;
                    if (ir[23:20] > 4'd8) err_n = 1'b1;
                end
            end
            S_WB: begin
                retire = 1'b1;
            end
            default: begin
                state_n = S_HALT;
            end
        endcase
        if (retire) begin
            cnt_n = cnt + 1'b1;
            if (RUN) begin
                state_n = S_FETCH;
                req_n   = 1'b1;
            end else begin
                state_n = S_IDLE;
            end
        end
        busy_n = (state_n == S_FETCH) || (state_n == S_READ) || (state_n == S_WB);
    end

    assign INSTR_REQ = req;
    assign A_CTRL    = a_sel;
    assign B_CTRL    = b_sel;
    assign C_CTRL    = c_sel;
    assign MR        = mr;
    assign ALU_OP    = alu;
    assign BUSY      = busy;
    assign HALTED    = halted;
    assign ERR       = err;
    assign INSTR_CNT = cnt;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Self-checking bench for reg_bank_sequencer: directed vector table, randomized
// instruction stream against a transaction-level model, and reset/halt/run-drop sequences.
module tb_reg_bank_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RUN = 1'b0;
    logic [23:0] INSTR = '0;
    logic        INSTR_ACK = 1'b0;
    logic        INSTR_REQ, MR, BUSY, HALTED, ERR;
    logic [4:0]  A_CTRL;
    logic [5:0]  B_CTRL, C_CTRL;
    logic [2:0]  ALU_OP;
    logic [15:0] INSTR_CNT;

    logic        req2, mr2, busy2, halted2, err2;
    logic [4:0]  a2;
    logic [5:0]  b2, c2;
    logic [2:0]  alu2;
    logic [1:0]  cnt2;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cnt_exp = 0;
    logic        err_exp = 1'b0;

    reg_bank_sequencer dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .INSTR(INSTR), .INSTR_ACK(INSTR_ACK),
        .INSTR_REQ(INSTR_REQ), .A_CTRL(A_CTRL), .B_CTRL(B_CTRL), .C_CTRL(C_CTRL),
        .MR(MR), .ALU_OP(ALU_OP), .BUSY(BUSY), .HALTED(HALTED), .ERR(ERR),
        .INSTR_CNT(INSTR_CNT)
    );

    // Narrow counter copy exercises the wrap-to-zero rule in a few instructions
    reg_bank_sequencer #(.CNT_W(2)) dut_w (
        .CLK(CLK), .RST(RST), .RUN(RUN), .INSTR(INSTR), .INSTR_ACK(INSTR_ACK),
        .INSTR_REQ(req2), .A_CTRL(a2), .B_CTRL(b2), .C_CTRL(c2),
        .MR(mr2), .ALU_OP(alu2), .BUSY(busy2), .HALTED(halted2), .ERR(err2),
        .INSTR_CNT(cnt2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [23:0] ins;
        int unsigned dly;
        logic [2:0]  alu;
        logic        mr;
        logic        wb;
        logic [5:0]  c;
        logic        err;
        logic        halt;
    } vec_t;

    function automatic logic [23:0] mk(input int unsigned opc, input int unsigned c,
                                       input int unsigned a, input int unsigned b);
        logic [3:0] o = 4'(opc);
        logic [5:0] cc = 6'(c);
        logic [4:0] aa = 5'(a);
        logic [5:0] bb = 6'(b);
        mk = {o, cc, aa, bb, 3'b101};
    endfunction

    function automatic vec_t model(input logic [23:0] ins, input int unsigned dly);
        vec_t v;
        int unsigned opc = int'(ins[23:20]);
        int unsigned c   = int'(ins[19:14]);
        logic        c_ill = (c >= 35 && c <= 62) || c == 28 || c == 29;
        v.ins  = ins;
        v.dly  = dly;
        v.alu  = (opc >= 1 && opc <= 6) ? 3'(opc - 1) : 3'd0;
        v.mr   = (opc == 7);
        v.wb   = (opc >= 1 && opc <= 6);
        v.halt = (opc == 8);
        v.c    = (v.wb && !c_ill) ? 6'(c) : 6'd63;
        v.err  = (opc >= 9) || (v.wb && c_ill);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_req();
        for (int n = 0; n < 10; n++) begin
            if (INSTR_REQ) break;
            tick();
        end
        chk("req_rise", 32'(INSTR_REQ), 1);
    endtask

    task automatic run_instr(input vec_t v, input bit drop_run, input bit rst_wb);
        for (int i = 0; i < int'(v.dly); i++) begin
            chk("req_hold", 32'(INSTR_REQ), 1);
            if (drop_run && i == 0) RUN = 1'b0;
            tick();
        end
        chk("req_at_ack", 32'(INSTR_REQ), 1);
        INSTR = v.ins;
        INSTR_ACK = 1'b1;
        tick();
        INSTR_ACK = 1'b0;
        INSTR = 24'($urandom);
        chk("read_req", 32'(INSTR_REQ), 0);
        chk("read_busy", 32'(BUSY), 1);
        chk("read_a", 32'(A_CTRL), 32'(v.ins[13:9]));
        chk("read_b", 32'(B_CTRL), 32'(v.ins[8:3]));
        chk("read_alu", 32'(ALU_OP), 32'(v.alu));
        chk("read_c", 32'(C_CTRL), 63);
        chk("read_mr", 32'(MR), 32'(v.mr));
        if (v.halt) begin
            tick();
            chk("halt_halted", 32'(HALTED), 1);
            chk("halt_busy", 32'(BUSY), 0);
            chk("halt_req", 32'(INSTR_REQ), 0);
            chk("halt_cnt", 32'(INSTR_CNT), cnt_exp & 32'hFFFF);
            return;
        end
        if (v.wb) begin
            tick();
            err_exp = err_exp | v.err;
            chk("wb_c", 32'(C_CTRL), 32'(v.c));
            chk("wb_a", 32'(A_CTRL), 32'(v.ins[13:9]));
            chk("wb_b", 32'(B_CTRL), 32'(v.ins[8:3]));
            chk("wb_alu", 32'(ALU_OP), 32'(v.alu));
            chk("wb_mr", 32'(MR), 0);
            chk("wb_err", 32'(ERR), 32'(err_exp));
            if (rst_wb) begin
                RST = 1'b1;
                #1;
                cnt_exp = 0;
                err_exp = 1'b0;
                chk("rst_c", 32'(C_CTRL), 63);
                chk("rst_mr", 32'(MR), 0);
                chk("rst_cnt", 32'(INSTR_CNT), 0);
                chk("rst_err", 32'(ERR), 0);
                chk("rst_busy", 32'(BUSY), 0);
                chk("rst_a", 32'(A_CTRL), 0);
                chk("rst_b", 32'(B_CTRL), 63);
                chk("rst_req", 32'(INSTR_REQ), 0);
                RST = 1'b0;
                return;
            end
        end
        tick();
        cnt_exp++;
        err_exp = err_exp | v.err;
        chk("ret_cnt", 32'(INSTR_CNT), cnt_exp & 32'hFFFF);
        chk("ret_cnt_wrap", 32'(cnt2), cnt_exp % 4);
        chk("ret_err", 32'(ERR), 32'(err_exp));
        chk("ret_req", 32'(INSTR_REQ), 32'(RUN));
        chk("ret_busy", 32'(BUSY), 32'(RUN));
        chk("ret_mr", 32'(MR), 0);
        chk("ret_c", 32'(C_CTRL), 63);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[8];
        tbl[0] = '{mk(2, 5, 3, 4),   2, 3'd1, 1'b0, 1'b1, 6'd5,  1'b0, 1'b0};
        tbl[1] = '{mk(7, 9, 1, 2),   1, 3'd0, 1'b1, 1'b0, 6'd63, 1'b0, 1'b0};
        tbl[2] = '{mk(0, 5, 6, 7),   1, 3'd0, 1'b0, 1'b0, 6'd63, 1'b0, 1'b0};
        tbl[3] = '{mk(1, 30, 7, 40), 1, 3'd0, 1'b0, 1'b1, 6'd30, 1'b0, 1'b0};
        tbl[4] = '{mk(1, 63, 2, 3),  1, 3'd0, 1'b0, 1'b1, 6'd63, 1'b0, 1'b0};
        tbl[5] = '{mk(1, 40, 2, 3),  1, 3'd0, 1'b0, 1'b1, 6'd63, 1'b1, 1'b0};
        tbl[6] = '{mk(1, 28, 4, 5),  2, 3'd0, 1'b0, 1'b1, 6'd63, 1'b1, 1'b0};
        tbl[7] = '{mk(12, 3, 4, 5),  1, 3'd0, 1'b0, 1'b0, 6'd63, 1'b1, 1'b0};

        tick();
        tick();
        chk("reset_req", 32'(INSTR_REQ), 0);
        chk("reset_b", 32'(B_CTRL), 63);
        chk("reset_c", 32'(C_CTRL), 63);
        chk("reset_busy", 32'(BUSY), 0);
        chk("reset_halted", 32'(HALTED), 0);
        chk("reset_cnt", 32'(INSTR_CNT), 0);
        RST = 1'b0;
        tick();
        chk("idle_req", 32'(INSTR_REQ), 0);
        RUN = 1'b1;
        wait_req();

        for (int i = 0; i < 8; i++) run_instr(tbl[i], 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [23:0] ins = 24'($urandom);
            if (ins[23:20] == 4'd8) ins[23:20] = 4'd0;
            run_instr(model(ins, $urandom_range(1, 3)), 1'b0, 1'b0);
        end

        run_instr(model(mk(2, 11, 1, 2), 1), 1'b0, 1'b1);
        wait_req();

        run_instr(model(mk(3, 12, 8, 9), 2), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stop_req", 32'(INSTR_REQ), 0);
            chk("stop_busy", 32'(BUSY), 0);
        end
        RUN = 1'b1;
        wait_req();
        run_instr(model(mk(8, 0, 0, 0), 1), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_stay_req", 32'(INSTR_REQ), 0);
            chk("halt_stay", 32'(HALTED), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
